// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// Latency: none, wires only.
// Backpressure: none; loads are strobes and the divider never stalls them.
interface clk_div_prog_if #(
   parameter int DIV_W = 8
);
   logic             i_en;
   logic [DIV_W-1:0] i_div;
   logic             i_div_load;
   logic             o_clk;
   logic             o_tick;
   logic [DIV_W-1:0] o_div_active;
   logic             o_busy;
   logic             o_div_ack;
   logic             o_div_err;

   // Driver side: the block that programs the divider and consumes its outputs.
   modport master (
      output i_en, i_div, i_div_load,
      input  o_clk, o_tick, o_div_active, o_busy, o_div_ack, o_div_err
   );

   // Divider side.
   modport slave (
      input  i_en, i_div, i_div_load,
      output o_clk, o_tick, o_div_active, o_busy, o_div_ack, o_div_err
   );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, exact 50% duty for odd and even N.
// Latency: new ratio takes effect at the next period boundary (1..N_old cycles).
// Backpressure: none; a load while one is pending replaces it, illegal ratios pulse o_div_err.
module clk_div_prog #(
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 5
) (
   input  logic          i_clk,
   input  logic          i_rst,
   clk_div_prog_if.slave bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_active;
   logic [DIV_W-1:0] div_pend;
   logic             busy;
   logic             p_q;
   logic             n_q;
   logic             tick_q;
   logic             ack_q;
   logic             err_q;

   logic             wrap;
   logic             boundary;
   logic             load_ok;
   logic [DIV_W-1:0] cnt_inc;
   logic [DIV_W-1:0] half_act;

   // Period bookkeeping: where the current period ends and whether a new ratio may land.
   always_comb begin
      wrap     = (state == ST_RUN) && (cnt == (div_active - ONE));
      boundary = (state == ST_IDLE) || wrap;
      load_ok  = bus.i_div_load && (bus.i_div >= TWO);
      cnt_inc  = cnt + ONE;
      half_act = div_active >> 1;
   end

   // Run/stop FSM, period counter, ratio shadowing and all posedge outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         div_active <= DIV_W'(DIV_DEFAULT);
         div_pend   <= '0;
         busy       <= 1'b0;
         p_q        <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;

         // A pending ratio only lands between periods, so o_clk never sees a runt.
         if (boundary && busy) begin
            div_active <= div_pend;
            busy       <= 1'b0;
            ack_q      <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (bus.i_en) begin
                  state  <= ST_RUN;
                  p_q    <= 1'b1;
                  tick_q <= 1'b1;
               end else begin
                  p_q <= 1'b0;
               end
            end
            ST_RUN: begin
               if (wrap) begin
                  cnt <= '0;
                  if (bus.i_en) begin
                     p_q    <= 1'b1;
                     tick_q <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                     p_q   <= 1'b0;
                  end
               end else begin
                  // High half covers counts 0..H-1; H >= 1 so count 0 is always high.
                  cnt <= cnt_inc;
                  p_q <= (cnt_inc < half_act);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               p_q   <= 1'b0;
            end
         endcase

         // Loading after the apply above means a same-cycle load becomes the next pending value.
         if (bus.i_div_load) begin
            if (load_ok) begin
               div_pend <= bus.i_div;
               busy     <= 1'b1;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   // Half-cycle extension for odd ratios; forced low for even ratios so o_clk is just p.
   always_ff @(negedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         n_q <= 1'b0;
      end else begin
         n_q <= p_q & div_active[0];
      end
   end

   assign bus.o_clk        = p_q | n_q;
   assign bus.o_tick       = tick_q;
   assign bus.o_div_active = div_active;
   assign bus.o_busy       = busy;
   assign bus.o_div_ack    = ack_q;
   assign bus.o_div_err    = err_q;

endmodule
